// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock through a single select/accumulate slice.
// Latency: out_valid rises WIDTH/2+1 edges after the accept edge; one operation in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready stays low until the result pops.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_unsign,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);
    localparam int ND = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(ND);
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand state walks with the digit index instead of using a barrel shifter:
    // mcand is pre-scaled by 4^i, mplier is shifted so its two LSBs are b[2i+1:2i].
    typedef struct packed {
        logic [AW-1:0] mcand;
        logic [EW-1:0] mplier;
        logic          prev;
    } opnd_t;

    state_t          state_q;
    state_t          state_d;
    opnd_t           opnd_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   ext_a;
    logic [EW-1:0]   ext_b;
    logic            capture;
    logic            last_digit;

    assign ext_a = in_unsign ? {{(AW-WIDTH){1'b0}}, in_a}
                             : {{(AW-WIDTH){in_a[WIDTH-1]}}, in_a};
    assign ext_b = in_unsign ? {2'b00, in_b}
                             : {{2{in_b[WIDTH-1]}}, in_b};

    assign capture    = (state_q == IDLE) && in_valid;
    assign last_digit = (cnt_q == LAST);

    always_comb begin
        pp = '0;
        unique case ({opnd_q.mplier[1:0], opnd_q.prev})
            3'b001, 3'b010: pp = opnd_q.mcand;
            3'b011:         pp = {opnd_q.mcand[AW-2:0], 1'b0};
            3'b100:         pp = -{opnd_q.mcand[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = -opnd_q.mcand;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake inputs are only looked at in the state that owns them, so an X
    // on an ignored input cannot steer the FSM.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (capture) begin
            acc_q         <= '0;
            opnd_q.mcand  <= ext_a;
            opnd_q.mplier <= ext_b;
            opnd_q.prev   <= 1'b0;
            cnt_q         <= '0;
        end else if (state_q == BUSY) begin
            acc_q         <= acc_q + pp;
            opnd_q.mcand  <= {opnd_q.mcand[AW-3:0], 2'b00};
            opnd_q.mplier <= {2'b00, opnd_q.mplier[EW-1:2]};
            opnd_q.prev   <= opnd_q.mplier[1];
            cnt_q         <= last_digit ? '0 : cnt_q + CW'(1);
        end
    end

    assign out_prod = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed vector table and corner sequences at WIDTH=8,
// randomized traffic at WIDTH=8 and WIDTH=32 against an integer-arithmetic reference.
module tb_booth_mul_seq;
    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, in_unsign8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_prod8;

    logic        in_valid32, in_ready32, in_unsign32, out_valid32, out_ready32, busy32;
    logic [31:0] in_a32, in_b32;
    logic [63:0] out_prod32;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_unsign(in_unsign8),
        .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_prod(out_prod8),
        .busy(busy8)
    );

    booth_mul_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_unsign(in_unsign32),
        .in_a(in_a32), .in_b(in_b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_prod(out_prod32),
        .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference products from plain integer multiplication.
    function automatic logic [15:0] ref8(input logic u, input logic [7:0] a, input logic [7:0] b);
        longint va, vb;
        va = u ? longint'(a) : longint'($signed(a));
        vb = u ? longint'(b) : longint'($signed(b));
        return 16'(va * vb);
    endfunction

    function automatic logic [63:0] ref32(input logic u, input logic [31:0] a, input logic [31:0] b);
        longint va, vb;
        va = u ? longint'(a) : longint'($signed(a));
        vb = u ? longint'(b) : longint'($signed(b));
        return 64'(va * vb);
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'hFF;
            2: return 8'h00;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the 8-bit DUT, scramble inputs after capture, return
    // the product and the number of edges from accept to out_valid.
    task automatic do_op8(input logic u, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat);
        int w;
        in_unsign8 = u; in_a8 = a; in_b8 = b; in_valid8 = 1'b1; out_ready8 = 1'b0;
        w = 0;
        while (!in_ready8 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_a8 = ~a; in_b8 = 8'($urandom); in_unsign8 = ~u;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        prod = out_prod8;
    endtask

    task automatic pop8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run_rand8(input int nops);
        logic [15:0] q[$];
        logic [15:0] e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < nops && cyc < 30000) begin
            in_a8 = pick8(); in_b8 = pick8(); in_unsign8 = 1'($urandom);
            in_valid8  = (sent < nops) && ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 2) != 0);
            if (in_valid8 && in_ready8) begin
                q.push_back(ref8(in_unsign8, in_a8, in_b8));
                sent++;
            end
            if (out_valid8 && out_ready8) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand8_order: product %0h with no pending op", out_prod8);
                end else begin
                    e = q.pop_front();
                    chk("rand8_prod", out_prod8, e);
                end
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        chk("rand8_count", got, nops);
    endtask

    task automatic run_rand32(input int nops);
        logic [63:0] q[$];
        logic [63:0] e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < nops && cyc < 40000) begin
            in_a32 = pick32(); in_b32 = pick32(); in_unsign32 = 1'($urandom);
            in_valid32  = (sent < nops) && ($urandom_range(0, 3) != 0);
            out_ready32 = ($urandom_range(0, 2) != 0);
            if (in_valid32 && in_ready32) begin
                q.push_back(ref32(in_unsign32, in_a32, in_b32));
                sent++;
            end
            if (out_valid32 && out_ready32) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand32_order: product %0h with no pending op", out_prod32);
                end else begin
                    e = q.pop_front();
                    chk("rand32_prod", out_prod32, e);
                end
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid32 = 1'b0; out_ready32 = 1'b0;
        chk("rand32_count", got, nops);
    endtask

    typedef struct {
        logic        u;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] p;
        logic [15:0] bp_exp;
        int lat;

        tbl[0] = '{1'b0, 8'hFD, 8'h05, 16'hFFF1};
        tbl[1] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{1'b0, 8'hFF, 8'hFF, 16'h0001};
        tbl[3] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        tbl[4] = '{1'b1, 8'h80, 8'hFF, 16'h7F80};
        tbl[5] = '{1'b0, 8'h00, 8'h5A, 16'h0000};
        tbl[6] = '{1'b1, 8'hA5, 8'h00, 16'h0000};
        tbl[7] = '{1'b0, 8'h7F, 8'h80, 16'hC080};
        tbl[8] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
        tbl[9] = '{1'b1, 8'h07, 8'h09, 16'h003F};

        rst_n = 1'b0;
        in_valid8 = 1'b0; in_unsign8 = 1'b0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b0;
        in_valid32 = 1'b0; in_unsign32 = 1'b0; in_a32 = '0; in_b32 = '0; out_ready32 = 1'b0;
        #12;
        chk("rst_in_ready8", in_ready8, 1'b1);
        chk("rst_out_valid8", out_valid8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_out_prod8", out_prod8, 16'h0);
        chk("rst_in_ready32", in_ready32, 1'b1);
        chk("rst_out_prod32", out_prod32, 64'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_op8(tbl[i].u, tbl[i].a, tbl[i].b, p, lat);
            chk($sformatf("vec%0d_prod", i), p, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            pop8();
        end

        // Backpressure: result must hold while new operands are offered.
        bp_exp = ref8(1'b0, 8'h9C, 8'h3B);
        do_op8(1'b0, 8'h9C, 8'h3B, p, lat);
        chk("bp_first_prod", p, bp_exp);
        for (int k = 0; k < 10; k++) begin
            in_valid8 = 1'b1; in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_unsign8 = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_hold_prod", out_prod8, bp_exp);
            chk("bp_hold_valid", out_valid8, 1'b1);
            chk("bp_hold_in_ready", in_ready8, 1'b0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("bp_pop_in_ready", in_ready8, 1'b1);
        chk("bp_pop_out_valid", out_valid8, 1'b0);
        chk("bp_pop_busy", busy8, 1'b0);
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        chk("bp_no_accept_on_pop", in_ready8, 1'b1);

        // Reset while digit 2 is being retired.
        in_valid8 = 1'b1; in_unsign8 = 1'b0; in_a8 = 8'h55; in_b8 = 8'h33;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_before_rst", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready8, 1'b1);
        chk("mid_rst_out_valid", out_valid8, 1'b0);
        chk("mid_rst_busy", busy8, 1'b0);
        chk("mid_rst_out_prod", out_prod8, 16'h0);
        @(posedge clk); #1;
        chk("mid_rst_held_valid", out_valid8, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op8(1'b0, 8'd7, 8'd9, p, lat);
        chk("post_rst_prod", p, 16'h003F);
        chk("post_rst_latency", lat, 5);
        pop8();

        run_rand8(1500);
        run_rand32(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
